buf_wt_rd_seq: RTL

Read-side sequencer for the convolution weight buffer. On a layer start it walks every weight-buffer address the conv datapath consumes and presents each one on a valid/ready request port that feeds the weight-buffer ack logic. That logic returns ready only once DMA has landed the address. Each output-channel weight block is replayed once per spatial tile before the sequencer advances to the next block.

---
 rtl/buf_wt_rd_seq_if.sv | 24 ++
 rtl/buf_wt_rd_seq.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/buf_wt_rd_seq_if.sv
// Weight-buffer read request channel: the sequencer presents addresses,
// the weight-buffer ack logic returns ready once DMA has landed the word.
interface buf_wt_rd_seq_if #(
  parameter int ADDR_W = 10
);
  logic              wt_addr_vld;
  logic [ADDR_W-1:0] wt_addr;
  logic              wt_addr_last;
  logic              wt_addr_rdy;

  modport master (
    output wt_addr_vld,
    output wt_addr,
    output wt_addr_last,
    input  wt_addr_rdy
  );

  modport slave (
    input  wt_addr_vld,
    input  wt_addr,
    input  wt_addr_last,
    output wt_addr_rdy
  );
endinterface

// File: rtl/buf_wt_rd_seq.sv
// Read-side sequencer for the convolution weight buffer. Walks every
// weight address of a layer: each output-channel block of L = kk*cin_grp
// words is replayed once per spatial tile before moving to the next block.
module buf_wt_rd_seq #(
  parameter int ADDR_W = 10,  // log2 of the weight-buffer depth
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fsm_logic_init,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_kk,
  input  logic [CNT_W-1:0]  cfg_cin_grp,
  input  logic [CNT_W-1:0]  cfg_cout_grp,
  input  logic [CNT_W-1:0]  cfg_tile_num,
  buf_wt_rd_seq_if.master   wt_if,
  output logic              busy,
  output logic              done
);

  localparam int LEN_W = 2 * CNT_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]        state_q,    state_d;
  logic [LEN_W-1:0]  len_q,      len_d;
  logic [CNT_W-1:0]  tile_num_q, tile_num_d;
  logic [CNT_W-1:0]  cout_grp_q, cout_grp_d;
  logic [LEN_W-1:0]  off_q,      off_d;
  logic [CNT_W-1:0]  tile_q,     tile_d;
  logic [CNT_W-1:0]  cout_q,     cout_d;
  logic [ADDR_W-1:0] blk_base_q, blk_base_d;

  logic             accept;
  logic             off_end;
  logic             tile_end;
  logic             cout_end;
  logic             cfg_zero;
  logic [LEN_W-1:0] cfg_len;

  // Block length is formed at full product width so no count combination overflows.
  assign cfg_len  = LEN_W'(cfg_kk) * LEN_W'(cfg_cin_grp);
  assign cfg_zero = (cfg_kk == '0) || (cfg_cin_grp == '0) ||
                    (cfg_cout_grp == '0) || (cfg_tile_num == '0);

  assign accept   = (state_q == ST_RUN) && wt_if.wt_addr_rdy;
  assign off_end  = (off_q  == len_q - LEN_W'(1));
  assign tile_end = (tile_q == tile_num_q - CNT_W'(1));
  assign cout_end = (cout_q == cout_grp_q - CNT_W'(1));

  // Next-state: FSM transitions and nested off/tile/cout walk.
  always_comb begin
    // NOTE: every _d defaults to its register so no path leaves a signal unassigned (no latches).
    state_d    = state_q;
    len_d      = len_q;
    tile_num_d = tile_num_q;
    cout_grp_d = cout_grp_q;
    off_d      = off_q;
    tile_d     = tile_q;
    cout_d     = cout_q;
    blk_base_d = blk_base_q;

    if (fsm_logic_init) begin
      // CSR abort beats everything: drop any in-flight request, no done pulse.
      state_d    = ST_IDLE;
      len_d      = '0;
      tile_num_d = '0;
      cout_grp_d = '0;
      off_d      = '0;
      tile_d     = '0;
      cout_d     = '0;
      blk_base_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          len_d      = cfg_len;
          tile_num_d = cfg_tile_num;
          cout_grp_d = cfg_cout_grp;
          blk_base_d = cfg_base_addr;
          off_d      = '0;
          tile_d     = '0;
          cout_d     = '0;
          state_d    = cfg_zero ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          if (accept) begin
            if (!off_end) begin
              off_d = off_q + LEN_W'(1);
            end else if (!tile_end) begin
              // Replay the same block for the next spatial tile.
              off_d  = '0;
              tile_d = tile_q + CNT_W'(1);
            end else if (!cout_end) begin
              off_d      = '0;
              tile_d     = '0;
              cout_d     = cout_q + CNT_W'(1);
              blk_base_d = blk_base_q + ADDR_W'(len_q);
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_d    = ST_IDLE;
          off_d      = '0;
          tile_d     = '0;
          cout_d     = '0;
          blk_base_d = '0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      tile_num_q <= '0;
      cout_grp_q <= '0;
      off_q      <= '0;
      tile_q     <= '0;
      cout_q     <= '0;
      blk_base_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      len_q      <= len_d;
      tile_num_q <= tile_num_d;
      cout_grp_q <= cout_grp_d;
      off_q      <= off_d;
      tile_q     <= tile_d;
      cout_q     <= cout_d;
      blk_base_q <= blk_base_d;
    end
  end

  // Valid is a pure state decode so it never depends on ready; the address
  // is one adder off the counter registers and wraps silently.
  assign wt_if.wt_addr_vld  = (state_q == ST_RUN);
  assign wt_if.wt_addr      = blk_base_q + ADDR_W'(off_q);
  assign wt_if.wt_addr_last = (state_q == ST_RUN) && off_end;
  assign busy               = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign done               = (state_q == ST_DONE);

endmodule
